// File: rtl/pingpong_group_buffer.sv
// Double-bank word buffer: the writer fills one bank while the reader drains the other.
// Banks hand over automatically; overruns either drop new words or replace the unread group.
module pingpong_group_buffer #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned MODE   = 0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iWrEn,
  input  logic [DATA_W-1:0] iWrData,
  input  logic              iSync,
  input  logic              iRdEn,
  input  logic [ADDR_W-1:0] iRdAddr,
  input  logic              iRdDone,
  output logic [DATA_W-1:0] oData,
  output logic              oRdValid,
  output logic              oSwitch,
  output logic              oBankReady,
  output logic              oOverrun,
  output logic [CNT_W-1:0]  oOvfCount,
  output logic [ADDR_W-1:0] oWrPtr
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  // Both banks share one array; the top address bit selects the bank
  logic [DATA_W-1:0] mem [2*DEPTH];

  logic              wb, rb;
  logic [1:0]        full;
  logic [ADDR_W-1:0] wr_ptr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              overrun;
  logic [CNT_W-1:0]  ovf_count;

  logic              wb_n, rb_n;
  logic [1:0]        full_n;
  logic [ADDR_W-1:0] ptr_base;
  logic [ADDR_W-1:0] ptr_n;
  logic              mem_we;
  logic [ADDR_W:0]   mem_waddr;
  logic              ovr_n;

  // Next bank state, applied in order: release, resync, write
  always_comb begin
    wb_n      = wb;
    rb_n      = rb;
    full_n    = full;
    ptr_base  = iSync ? '0 : wr_ptr;
    ptr_n     = ptr_base;
    mem_we    = 1'b0;
    mem_waddr = {wb, ptr_base};
    ovr_n     = 1'b0;

    if (iRdDone && full[rb]) begin
      full_n[rb] = 1'b0;
      rb_n       = ~rb;
    end

    if (iWrEn) begin
      if (!full_n[wb]) begin
        mem_we = 1'b1;
        if (&ptr_base) begin
          full_n[wb] = 1'b1;
          wb_n       = ~wb;
          ptr_n      = '0;
        end else begin
          ptr_n = ptr_base + ADDR_W'(1);
        end
      end else begin
        ovr_n = 1'b1;
        // Replace the stale group in the non-reader bank; the reader's bank stays intact
        if (MODE == 1) begin
          full_n[~rb_n] = 1'b0;
          wb_n          = ~rb_n;
          mem_we        = 1'b1;
          mem_waddr     = {~rb_n, {ADDR_W{1'b0}}};
          ptr_n         = ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wb        <= 1'b0;
      rb        <= 1'b0;
      full      <= 2'b00;
      wr_ptr    <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overrun   <= 1'b0;
      ovf_count <= '0;
    end else begin
      wb       <= wb_n;
      rb       <= rb_n;
      full     <= full_n;
      wr_ptr   <= ptr_n;
      overrun  <= ovr_n;
      rd_valid <= iRdEn && full[rb];
      if (iRdEn && full[rb]) begin
        rd_data <= mem[{rb, iRdAddr}];
      end
      if (ovr_n && (ovf_count != '1)) begin
        ovf_count <= ovf_count + CNT_W'(1);
      end
    end
  end

  // Storage is not cleared by reset
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      mem[mem_waddr] <= iWrData;
    end
  end

  assign oData      = rd_data;
  assign oRdValid   = rd_valid;
  assign oSwitch    = rb;
  assign oBankReady = full[rb];
  assign oOverrun   = overrun;
  assign oOvfCount  = ovf_count;
  assign oWrPtr     = wr_ptr;

endmodule

// File: tb/tb_pingpong_group_buffer.sv
// Directed bench for pingpong_group_buffer: one drop-mode and one overwrite-mode instance
// share the same stimulus; table vectors plus hand sequences for overrun, resync and reset.
module tb_pingpong_group_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [11:0] wr_data;
  logic        sync;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic        rd_done;

  logic [11:0] d0_data, d1_data;
  logic        d0_valid, d1_valid;
  logic        d0_sw, d1_sw;
  logic        d0_ready, d1_ready;
  logic        d0_ovr, d1_ovr;
  logic [15:0] d0_cnt, d1_cnt;
  logic [2:0]  d0_ptr, d1_ptr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pingpong_group_buffer #(.DATA_W(12), .ADDR_W(3), .MODE(0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .iWrEn(wr_en), .iWrData(wr_data), .iSync(sync),
    .iRdEn(rd_en), .iRdAddr(rd_addr), .iRdDone(rd_done),
    .oData(d0_data), .oRdValid(d0_valid), .oSwitch(d0_sw), .oBankReady(d0_ready),
    .oOverrun(d0_ovr), .oOvfCount(d0_cnt), .oWrPtr(d0_ptr)
  );

  pingpong_group_buffer #(.DATA_W(12), .ADDR_W(3), .MODE(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .iWrEn(wr_en), .iWrData(wr_data), .iSync(sync),
    .iRdEn(rd_en), .iRdAddr(rd_addr), .iRdDone(rd_done),
    .oData(d1_data), .oRdValid(d1_valid), .oSwitch(d1_sw), .oBankReady(d1_ready),
    .oOverrun(d1_ovr), .oOvfCount(d1_cnt), .oWrPtr(d1_ptr)
  );

  typedef struct {
    logic        we;
    logic [11:0] wd;
    logic        re;
    logic [2:0]  ra;
    logic        rdn;
    logic        ev;
    logic [11:0] ed;
    logic        esw;
    logic        erdy;
    logic [2:0]  eptr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic we, input logic [11:0] wd, input logic re,
                              input logic [2:0] ra, input logic rdn, input logic ev,
                              input logic [11:0] ed, input logic esw, input logic erdy,
                              input logic [2:0] eptr);
    vec_t v;
    v.we = we; v.wd = wd; v.re = re; v.ra = ra; v.rdn = rdn;
    v.ev = ev; v.ed = ed; v.esw = esw; v.erdy = erdy; v.eptr = eptr;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; return at the next falling edge
  task automatic drive(input logic we, input logic [11:0] wd, input logic sy,
                       input logic re, input logic [2:0] ra, input logic rdn);
    wr_en = we; wr_data = wd; sync = sy; rd_en = re; rd_addr = ra; rd_done = rdn;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0; wr_data = '0; sync = 1'b0; rd_en = 1'b0; rd_addr = '0; rd_done = 1'b0;
  endtask

  task automatic wr(input logic [11:0] d);
    drive(1'b1, d, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic rd(input logic [2:0] a);
    drive(1'b0, 12'h0, 1'b0, 1'b1, a, 1'b0);
  endtask

  task automatic rdone();
    drive(1'b0, 12'h0, 1'b0, 1'b0, 3'd0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Vectors: fill bank 0, read it, fill bank 1, release, read, release to empty
    for (int i = 0; i < 8; i++)
      add(1'b1, 12'(i + 1), 1'b0, 3'd0, 1'b0, 1'b0, 12'h0, 1'b0, (i == 7), 3'(i + 1));
    for (int a = 0; a < 8; a++)
      add(1'b0, 12'h0, 1'b1, 3'(a), 1'b0, 1'b1, 12'(a + 1), 1'b0, 1'b1, 3'd0);
    for (int i = 0; i < 8; i++)
      add(1'b1, 12'(i + 9), 1'b0, 3'd0, 1'b0, 1'b0, 12'h0, 1'b0, 1'b1, 3'(i + 1));
    add(1'b0, 12'h0, 1'b0, 3'd0, 1'b1, 1'b0, 12'h0, 1'b1, 1'b1, 3'd0);
    for (int a = 0; a < 8; a++)
      add(1'b0, 12'h0, 1'b1, 3'(a), 1'b0, 1'b1, 12'(a + 9), 1'b1, 1'b1, 3'd0);
    add(1'b0, 12'h0, 1'b0, 3'd0, 1'b1, 1'b0, 12'h0, 1'b0, 1'b0, 3'd0);
    add(1'b0, 12'h0, 1'b1, 3'd0, 1'b0, 1'b0, 12'h0, 1'b0, 1'b0, 3'd0);
    add(1'b0, 12'h0, 1'b1, 3'd5, 1'b0, 1'b0, 12'h0, 1'b0, 1'b0, 3'd0);
    add(1'b0, 12'h0, 1'b0, 3'd0, 1'b1, 1'b0, 12'h0, 1'b0, 1'b0, 3'd0);

    reset = 1'b0;
    wr_en = 1'b0; wr_data = '0; sync = 1'b0; rd_en = 1'b0; rd_addr = '0; rd_done = 1'b0;
    @(negedge clk);
    drive(1'b0, 12'h0, 1'b0, 1'b0, 3'd0, 1'b0);
    drive(1'b0, 12'h0, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("rst d0_data", d0_data, 0);
    chk("rst d0_valid", d0_valid, 0);
    chk("rst d0_sw", d0_sw, 0);
    chk("rst d0_ready", d0_ready, 0);
    chk("rst d0_ovr", d0_ovr, 0);
    chk("rst d0_cnt", d0_cnt, 0);
    chk("rst d0_ptr", d0_ptr, 0);
    chk("rst d1_ready", d1_ready, 0);
    chk("rst d1_cnt", d1_cnt, 0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].wd, 1'b0, vecs[i].re, vecs[i].ra, vecs[i].rdn);
      chk($sformatf("vec%0d d0_valid", i), d0_valid, vecs[i].ev);
      chk($sformatf("vec%0d d1_valid", i), d1_valid, vecs[i].ev);
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d d0_data", i), d0_data, vecs[i].ed);
        chk($sformatf("vec%0d d1_data", i), d1_data, vecs[i].ed);
      end
      chk($sformatf("vec%0d d0_sw", i), d0_sw, vecs[i].esw);
      chk($sformatf("vec%0d d1_sw", i), d1_sw, vecs[i].esw);
      chk($sformatf("vec%0d d0_ready", i), d0_ready, vecs[i].erdy);
      chk($sformatf("vec%0d d1_ready", i), d1_ready, vecs[i].erdy);
      chk($sformatf("vec%0d d0_ptr", i), d0_ptr, vecs[i].eptr);
      chk($sformatf("vec%0d d1_ptr", i), d1_ptr, vecs[i].eptr);
      chk($sformatf("vec%0d d0_ovr", i), d0_ovr, 0);
      chk($sformatf("vec%0d d0_cnt", i), d0_cnt, 0);
    end

    // Overrun: both banks full, then a third group; drop vs overwrite
    for (int i = 0; i < 16; i++) wr(12'(i + 1));
    chk("full d0_ready", d0_ready, 1);
    chk("full d1_ready", d1_ready, 1);
    chk("full d0_ptr", d0_ptr, 0);
    for (int k = 1; k <= 3; k++) begin
      wr(12'(12'h100 + k));
      chk($sformatf("ovr%0d d0_ovr", k), d0_ovr, 1);
      chk($sformatf("ovr%0d d0_cnt", k), d0_cnt, 32'(k));
      chk($sformatf("ovr%0d d0_ptr", k), d0_ptr, 0);
      chk($sformatf("ovr%0d d1_ovr", k), d1_ovr, (k == 1));
      chk($sformatf("ovr%0d d1_cnt", k), d1_cnt, 1);
      chk($sformatf("ovr%0d d1_ptr", k), d1_ptr, 32'(k));
    end
    for (int k = 4; k <= 8; k++) begin
      wr(12'(12'h100 + k));
      chk($sformatf("ovr%0d d0_cnt", k), d0_cnt, 32'(k));
      chk($sformatf("ovr%0d d1_ovr", k), d1_ovr, 0);
      chk($sformatf("ovr%0d d1_cnt", k), d1_cnt, 1);
    end
    chk("ovr d1_ptr wrap", d1_ptr, 0);
    drive(1'b0, 12'h0, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("ovr d0_ovr pulse end", d0_ovr, 0);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      chk($sformatf("ovr bank0 d0[%0d]", a), d0_data, 32'(a + 1));
      chk($sformatf("ovr bank0 d1[%0d]", a), d1_data, 32'(a + 1));
    end
    rdone();
    chk("ovr rel d0_sw", d0_sw, 1);
    chk("ovr rel d1_sw", d1_sw, 1);
    chk("ovr rel d1_ready", d1_ready, 1);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      chk($sformatf("ovr bank1 d0[%0d]", a), d0_data, 32'(a + 9));
      chk($sformatf("ovr bank1 d1[%0d]", a), d1_data, 32'(12'h101 + a));
      chk($sformatf("ovr bank1 d1_valid[%0d]", a), d1_valid, 1);
    end
    rdone();
    chk("ovr empty d0_ready", d0_ready, 0);
    chk("ovr empty d1_sw", d1_sw, 0);

    // Resync: partial group discarded, sync with write lands at address 0
    for (int i = 0; i < 5; i++) wr(12'(12'h201 + i));
    chk("sync pre ptr", d0_ptr, 5);
    drive(1'b0, 12'h0, 1'b1, 1'b0, 3'd0, 1'b0);
    chk("sync alone ptr", d0_ptr, 0);
    for (int i = 0; i < 3; i++) wr(12'(12'h301 + i));
    drive(1'b1, 12'h311, 1'b1, 1'b0, 3'd0, 1'b0);
    chk("sync+wr ptr", d0_ptr, 1);
    chk("sync+wr d1_ptr", d1_ptr, 1);
    for (int i = 1; i < 8; i++) wr(12'(12'h311 + i));
    chk("sync d0_ready", d0_ready, 1);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      chk($sformatf("sync bank0 d0[%0d]", a), d0_data, 32'(12'h311 + a));
      chk($sformatf("sync bank0 d1[%0d]", a), d1_data, 32'(12'h311 + a));
    end
    rdone();
    chk("sync rel sw", d0_sw, 1);
    chk("sync rel ready", d0_ready, 0);

    // Mid-group reset, then release coinciding with a write into the freed bank
    for (int i = 0; i < 4; i++) wr(12'(12'h501 + i));
    chk("mid ptr", d0_ptr, 4);
    reset = 1'b0;
    drive(1'b0, 12'h0, 1'b0, 1'b0, 3'd0, 1'b0);
    reset = 1'b1;
    chk("mid rst d0_ptr", d0_ptr, 0);
    chk("mid rst d0_ready", d0_ready, 0);
    chk("mid rst d0_cnt", d0_cnt, 0);
    chk("mid rst d0_sw", d0_sw, 0);
    chk("mid rst d1_cnt", d1_cnt, 0);
    for (int i = 0; i < 16; i++) wr(12'(12'h401 + i));
    chk("rel+wr pre ready", d0_ready, 1);
    drive(1'b1, 12'h4FF, 1'b0, 1'b0, 3'd0, 1'b1);
    chk("rel+wr d0_ovr", d0_ovr, 0);
    chk("rel+wr d1_ovr", d1_ovr, 0);
    chk("rel+wr d0_cnt", d0_cnt, 0);
    chk("rel+wr d0_ptr", d0_ptr, 1);
    chk("rel+wr d0_sw", d0_sw, 1);
    rd(3'd0);
    chk("rel+wr rd valid", d0_valid, 1);
    chk("rel+wr rd data", d0_data, 12'h409);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pingpong_group_buffer.md
Name: pingpong_group_buffer

Overview:
- Parametrised double-bank (ping-pong) word buffer between the serial word receiver (write side) and the frame former (read side).
- The writer fills one bank while the reader drains the other. Bank hand-over is automatic, with full/empty tracking and overrun accounting.
- Overrun policy is selectable: drop the new data, or replace the stale unread group.
- Memory is internal and inferred; no external bank muxing is needed.

Parameters:
DATA_W, 12, word width
ADDR_W, 10, address width; bank depth DEPTH = 2**ADDR_W words
MODE, 0, overrun policy: 0 = drop new words, 1 = overwrite unread bank with newest group
CNT_W, 16, overrun counter width

Ports:
clk  in  1  system clock; the only clock
reset  in  1  synchronous, active-low reset (0 = reset)
iWrEn  in  1  write strobe, one word per cycle
iWrData  in  DATA_W  word to store
iSync  in  1  group resync: restarts the write pointer of the current bank at 0
iRdEn  in  1  read strobe
iRdAddr  in  ADDR_W  read address within the reader bank
iRdDone  in  1  reader releases its bank (1-cycle pulse)
oData  out  DATA_W  read data
oRdValid  out  1  oData valid
oSwitch  out  1  index of the bank the reader owns (rb)
oBankReady  out  1  reader bank is full and readable
oOverrun  out  1  1-cycle pulse per overrun event
oOvfCount  out  CNT_W  saturating overrun count
oWrPtr  out  ADDR_W  current write address

Behaviour:
- Reset is sampled on the clk edge while reset==0. Reset values:
  - wb=0, rb=0, full=2'b00, wrPtr=0
  - oData=0, oRdValid=0, oOverrun=0, oOvfCount=0
  - Memory contents are not cleared.
- Outputs: oSwitch=rb, oBankReady=full[rb], oWrPtr=wrPtr.
- Bank state is full[1:0] plus pointers wb (writer bank) and rb (reader bank).
- Per-cycle evaluation order: reset, then iRdDone, then iSync, then iWrEn.
- Release:
  - iRdDone && full[rb]: full[rb]<=0, rb<=~rb.
  - iRdDone while !full[rb] is ignored.
  - The release takes effect for a write in the same cycle, so a simultaneous last-read-release and write is not an overrun.
- Resync:
  - iSync: wrPtr<=0; the partial group in wb is discarded; full flags are unchanged.
  - iSync && iWrEn in the same cycle: the word is written at address 0, then wrPtr<=1.
- Write with !full[wb]:
  - mem[wb][wrPtr]<=iWrData; wrPtr<=wrPtr+1.
  - When wrPtr==DEPTH-1: full[wb]<=1, wb<=~wb, wrPtr wraps to 0.
- Overrun occurs on a write with full[wb] (only possible when wb==rb, i.e. both banks full). In both modes: oOverrun pulses 1 cycle and oOvfCount increments, saturating at all-ones.
  - MODE 0: the word is dropped; wrPtr is unchanged; each dropped word counts.
  - MODE 1: full[~rb]<=0, wb<=~rb, the word is written at address 0 of ~rb, wrPtr<=1. The reader's bank is never touched. Counts once per overwritten group.
- Read latency is 1 cycle: oData<=mem[rb][iRdAddr], oRdValid<=iRdEn&&full[rb].
  - If iRdEn && !full[rb]: oRdValid<=0 and oData holds its previous value.
  - A read and a release in the same cycle read the pre-release rb.
- Mid-operation reset drops all buffered groups immediately; the bench must not expect old data after reset.

Test Plan:
1. ADDR_W=3, MODE=0: reset low 2 cycles, then write 8 words 0x001..0x008 -> full=01, oBankReady=1, oSwitch=0, wb=1; reading addresses 0..7 returns 0x001..0x008, each 1 cycle after iRdEn with oRdValid=1.
2. Continue writing 0x009..0x010 into bank 1; iRdDone -> oSwitch=1, oBankReady=1; reads return 0x009..0x010; a second iRdDone -> oBankReady=0 and oRdValid stays 0 on subsequent reads.
3. MODE=0: fill both banks (16 words) with no iRdDone, write 3 more -> 3 oOverrun pulses, oOvfCount=3, oWrPtr unchanged; bank 0 still reads back its original data.
4. MODE=1: same as scenario 3 but the third group is 0x101..0x108 -> oOvfCount=1; after iRdDone, bank 1 reads 0x101..0x108.
5. Write 5 words, pulse iSync, write 8 words -> bank 0 holds only the 8 post-sync words; iSync together with iWrEn places that word at address 0.
6. Assert reset=0 mid-group after 4 words -> next cycle oWrPtr=0, oBankReady=0, oOvfCount=0; with both banks full, write the last word in the same cycle as iRdDone -> no oOverrun.
